// File: rtl/fp32_pkg.sv
// fp32_pkg: shared fp32 field constants, operand/stage payload types and helpers
package fp32_pkg;
    localparam int EXP_W = 8;
    localparam int MANT_W = 23;
    localparam int BIAS = 127;
    localparam int EXP_MAX = 255;
    localparam logic [31:0] QNAN = 32'h7FC00000;
    localparam logic [31:0] PINF = 32'h7F800000;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [23:0] mant;
    } unpacked_t;

    typedef struct packed {
        logic        valid;
        logic        spl;
        logic [31:0] spl_val;
        logic        sign;
        logic [7:0]  exp;
        logic [26:0] mant;
        logic [26:0] mant_small;
        logic        eff_sub;
    } align_t;

    typedef struct packed {
        logic        valid;
        logic        spl;
        logic [31:0] spl_val;
        logic        sign;
        logic [7:0]  exp;
        logic [27:0] mant;
        logic        eff_sub;
    } add_t;

    // exponent field 0 flushes to signed zero
    function automatic unpacked_t unpack(input logic [31:0] x);
        unpacked_t u;
        u.sign = x[31];
        u.exp = x[30:23];
        u.mant = (x[30:23] == 8'd0) ? 24'd0 : {1'b1, x[22:0]};
        return u;
    endfunction

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction
endpackage

// File: rtl/fp_lzc28.sv
// fp_lzc28: combinational 28-bit leading-zero counter
module fp_lzc28 (
    input  logic [27:0] d,
    output logic [4:0]  cnt
);
    always_comb begin
        cnt = 5'd28;
        for (int i = 0; i < 28; i++)
            if (d[i]) cnt = 5'(27 - i);
    end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined fp32 adder with in-order special-case bypass
module fp_add_pipe #(
    parameter int LAT = 3,
    parameter int MANT_W = 23,
    parameter int EXP_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        spl_case,
    input  logic [31:0] spl_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        ovf,
    output logic        invalid
);
    import fp32_pkg::*;

    logic adv;
    logic [EXP_W-1:0] ea, eb;
    logic [MANT_W-1:0] fa, fb;
    logic a_inf, b_inf, a_nan, b_nan, inf_clash, swap;
    unpacked_t ua, ub, big, sml;
    logic [7:0] d;
    logic [4:0] sh;
    logic [53:0] wide;
    align_t s1_d, s1;
    add_t s2_d, s2;
    logic [4:0] lz;
    logic [27:0] sl;
    logic [26:0] m;
    logic signed [9:0] e, ef;
    logic up;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic [31:0] res_d;
    logic ovf_d, inv_d;

    assign adv = ~out_valid | out_ready;
    assign in_ready = adv;

    assign ea = A[MANT_W +: EXP_W];
    assign eb = B[MANT_W +: EXP_W];
    assign fa = A[MANT_W-1:0];
    assign fb = B[MANT_W-1:0];

    always_comb begin
        a_inf = (ea == '1) && (fa == '0);
        b_inf = (eb == '1) && (fb == '0);
        a_nan = (ea == '1) && (fa != '0);
        b_nan = (eb == '1) && (fb != '0);
        inf_clash = a_inf & b_inf & (A[31] ^ B[31]);
        ua = unpack(A);
        ub = unpack(B);
        swap = {ub.exp, ub.mant} > {ua.exp, ua.mant};
        big = swap ? ub : ua;
        sml = swap ? ua : ub;
        d = big.exp - sml.exp;
        sh = (d > 8'd27) ? 5'd27 : d[4:0];
        // everything shifted below R collapses into the sticky bit
        wide = {sml.mant, 3'b000, 27'd0} >> sh;
        s1_d.valid = in_valid;
        s1_d.spl = inf_clash | spl_case | a_nan | b_nan | a_inf | b_inf;
        s1_d.spl_val = inf_clash ? QNAN : spl_case ? spl_result :
                       (a_nan | b_nan) ? QNAN : a_inf ? A : B;
        s1_d.sign = big.sign;
        s1_d.exp = big.exp;
        s1_d.mant = {big.mant, 3'b000};
        s1_d.mant_small = {wide[53:28], wide[27] | (|wide[26:0])};
        s1_d.eff_sub = ua.sign ^ ub.sign;
    end

    always_comb begin
        s2_d.valid = s1.valid;
        s2_d.spl = s1.spl;
        s2_d.spl_val = s1.spl_val;
        s2_d.sign = s1.sign;
        s2_d.exp = s1.exp;
        s2_d.eff_sub = s1.eff_sub;
        s2_d.mant = s1.eff_sub ? {1'b0, s1.mant} - {1'b0, s1.mant_small}
                               : {1'b0, s1.mant} + {1'b0, s1.mant_small};
    end

    fp_lzc28 u_lzc (.d(s2.mant), .cnt(lz));

    always_comb begin
        sl = s2.mant << (lz - 5'd1);
        m = s2.mant[27] ? {s2.mant[27:2], s2.mant[1] | s2.mant[0]} : sl[26:0];
        e = s2.mant[27] ? $signed({2'b00, s2.exp}) + 10'sd1
                        : $signed({2'b00, s2.exp}) - $signed({5'd0, lz}) + 10'sd1;
        up = m[2] & (m[1] | m[0] | m[3]);
        rnd = {1'b0, m[26:3]} + {24'd0, up};
        ef = e + $signed({9'd0, rnd[24]});
        frac = rnd[24] ? rnd[23:1] : rnd[22:0];
        // exact zero keeps the sign only when both addends agreed on it
        res_d = s2.spl ? s2.spl_val :
                (s2.mant == 28'd0) ? {s2.sign & ~s2.eff_sub, 31'd0} :
                (ef >= EXP_MAX) ? {s2.sign, PINF[30:0]} :
                (ef <= 0) ? 32'd0 : {s2.sign, ef[7:0], frac};
        ovf_d = ~s2.spl & (s2.mant != 28'd0) & (ef >= EXP_MAX);
        inv_d = s2.spl & is_nan(s2.spl_val);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            out_valid <= 1'b0;
            result <= 32'd0;
            ovf <= 1'b0;
            invalid <= 1'b0;
        end else if (adv) begin
            s1 <= s1_d;
            s2 <= s2_d;
            out_valid <= s2.valid;
            result <= res_d;
            ovf <= ovf_d;
            invalid <= inv_d;
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed scoreboard bench for fp_add_pipe
module tb_fp_add_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_ready;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic spl_case = 1'b0;
    logic [31:0] spl_result = 32'd0;
    logic out_valid;
    logic out_ready = 1'b1;
    logic [31:0] result;
    logic ovf;
    logic invalid;
    int tests = 0;
    int fails = 0;
    logic [33:0] q[$];
    logic [31:0] hold;

    fp_add_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .spl_case(spl_case), .spl_result(spl_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .ovf(ovf), .invalid(invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            assert (q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_out: got %h expected none", result);
            end
            if (q.size() != 0) check("out{result,ovf,invalid}", {result, ovf, invalid}, q.pop_front());
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sc,
                        input logic [31:0] sr, input logic [31:0] er, input logic eo, input logic ei);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        A = a;
        B = b;
        spl_case = sc;
        spl_result = sr;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", {33'd0, in_ready}, 34'd1);
        q.push_back({er, eo, ei});
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 34'(q.size()), 34'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_out", {result, ovf, invalid}, 34'd0);
        check("reset_valid", {33'd0, out_valid}, 34'd0);
        rst = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'd0, 32'h40000000, 1'b0, 1'b0);
        idle();
        check("lat_c1", {33'd0, out_valid}, 34'd0);
        @(negedge clk);
        check("lat_c2", {33'd0, out_valid}, 34'd0);
        @(negedge clk);
        check("lat_c3", {33'd0, out_valid}, 34'd1);
        drain();
        send(32'h3FC00000, 32'h40100000, 1'b0, 32'd0, 32'h40700000, 1'b0, 1'b0);
        send(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h3F800000, 32'hBF800000, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'd0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33C00000, 1'b0, 32'd0, 32'h3F800001, 1'b0, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'd0, 32'h7F800000, 1'b1, 1'b0);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'd0, 32'h7FC00000, 1'b0, 1'b1);
        send(32'h40000000, 32'hBF000000, 1'b0, 32'd0, 32'h3FC00000, 1'b0, 1'b0);
        send(32'h80000000, 32'h80000000, 1'b0, 32'd0, 32'h80000000, 1'b0, 1'b0);
        send(32'h80000000, 32'h00000000, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0);
        send(32'h00000001, 32'h3F800000, 1'b0, 32'd0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h00800000, 32'h80800001, 1'b0, 32'd0, 32'h00000000, 1'b0, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'd0, 32'h7FC00000, 1'b0, 1'b1);
        send(32'hFF800000, 32'h3F800000, 1'b0, 32'd0, 32'hFF800000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h32000000, 1'b0, 32'd0, 32'h3F800000, 1'b0, 1'b0);
        send(32'h3F800001, 32'hB2000000, 1'b0, 32'd0, 32'h3F800001, 1'b0, 1'b0);
        send(32'h00000000, 32'h00000000, 1'b1, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
        send(32'h00000000, 32'h00000000, 1'b1, 32'h7F800000, 32'h7F800000, 1'b0, 1'b0);
        idle();
        drain();
        // back-pressure: stall after the first result leaves
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'd0, 32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 32'hBF000000, 1'b0, 32'd0, 32'h3FC00000, 1'b0, 1'b0);
        send(32'h3FC00000, 32'h40100000, 1'b0, 32'd0, 32'h40700000, 1'b0, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'd0, 32'h3F800000, 1'b0, 1'b0);
        idle();
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        check("first_out_seen", {33'd0, out_valid}, 34'd1);
        @(posedge clk);
        #1 out_ready = 1'b0;
        hold = result;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", {33'd0, in_ready}, 34'd0);
            check("stall_valid", {33'd0, out_valid}, 34'd1);
            check("stall_hold", {2'b00, result}, {2'b00, hold});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        drain();
        // reset mid-stream discards in-flight work
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'd0, 32'h40000000, 1'b0, 1'b0);
        send(32'h40000000, 32'hBF000000, 1'b0, 32'd0, 32'h3FC00000, 1'b0, 1'b0);
        send(32'h3FC00000, 32'h40100000, 1'b0, 32'd0, 32'h40700000, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        #1 check("rst_valid", {33'd0, out_valid}, 34'd0);
        check("rst_out", {result, ovf, invalid}, 34'd0);
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("post_rst_quiet", {33'd0, out_valid}, 34'd0);
        send(32'h3F800000, 32'h33C00000, 1'b0, 32'd0, 32'h3F800001, 1'b0, 1'b0);
        idle();
        drain();
        repeat (10) @(negedge clk);
        check("final_empty", 34'(q.size()), 34'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Three-stage pipelined IEEE-754 single-precision adder datapath.
- Sits directly downstream of the special-case stage. It consumes operands A/B together with that stage's spl_case/result pair in the same cycle.
- Normal operands go through align/add/normalize/round. Special cases bypass the arithmetic in lockstep, so ordering and latency stay uniform.
- Valid/ready handshake on both sides, with a global stall.

Parameters:
- LAT, 3, pipeline depth in cycles; fixed, exposed for benches only.
- MANT_W, 23, fraction width.
- EXP_W, 8, exponent width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  block accepts this cycle.
- A  in  32  operand A (fp32).
- B  in  32  operand B (fp32).
- spl_case  in  1  upstream special-case hit.
- spl_result  in  32  upstream special-case result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- result  out  32  sum (fp32).
- ovf  out  1  result overflowed to infinity.
- invalid  out  1  result is NaN.

Behaviour:
- Reset (async, rst=1): all stage valid bits 0; out_valid=0, result=0, ovf=0, invalid=0. Reset mid-operation discards all in-flight data. The first accept after rst falls is in the cycle following deassertion.
- Handshake:
  - Transfer on in_valid & in_ready. Output retires on out_valid & out_ready.
  - adv = ~out_valid | out_ready; in_ready = adv.
  - All three stage registers load only when adv=1. When adv=0 every stage holds, including bubbles.
  - result and the flags are stable while out_valid=1 and out_ready=0.
- Latency: exactly 3 adv-cycles from accept to out_valid. Throughput is 1 per cycle when out_ready stays high.
- Bubbles: each stage carries a valid bit, and bubbles propagate.
- Special path (stage 1 decides, result carried to stage 3 unchanged):
  - spl_case=1: output spl_result; invalid=1 iff spl_result is NaN (exp all ones, frac≠0); ovf=0.
  - spl_case=0 with both operands infinite and signs different: output 0x7FC00000, invalid=1. This is not masked by the upstream flag.
  - spl_case=0 with any other inf/NaN operand: same rule as spl_case=1, but using 0x7FC00000 for NaN and the infinite operand itself for inf.
- Denormals: exponent field 0 is treated as signed zero on input (flush-to-zero). Results below the normal range flush to +0.
- Stage 1 (unpack/align):
  - Attach the hidden 1; the operand with the larger {exp,frac} becomes big.
  - d = exp_big − exp_small.
  - Shift the small mantissa right by min(d,27) into a 27-bit field {1.frac, G, R, S}. S = OR of all bits shifted past R. For d≥27 the small mantissa collapses to S only.
- Stage 2 (add):
  - eff_sub = sign_a ^ sign_b.
  - 28-bit sum/difference, with big minus small when subtracting, so it is never negative.
  - Result sign = sign_big.
- Stage 3 (normalize/round/pack):
  - Carry out: shift right 1, exp+1, and OR the lost bit into S.
  - Otherwise: leading-zero count, shift left, exp−lzc.
  - Round to nearest even: round up iff G & (R | S | lsb). A rounding carry renormalizes with exp+1.
  - exp ≥ 255 gives ±inf (0x7F800000 / 0xFF800000) with ovf=1.
  - exp ≤ 0 gives +0.
  - An exact-zero difference gives +0 (0x00000000).
  - Both inputs zero: sign = sign_a & sign_b.

Decomposition:
- Shared package fp32_pkg:
  - Field constants: EXP_W, MANT_W, BIAS=127, EXP_MAX=255.
  - QNAN=32'h7FC00000, PINF=32'h7F800000.
  - Unpacked-operand struct {sign, exp, mant}.
  - Per-stage payload structs {valid, spl, spl_val, sign, exp, mant, eff_sub}.
- One sub-module: fp_lzc28, a combinational 28-bit leading-zero counter with 5-bit output, used in stage 3.

Test Plan:
- A=0x3F800000, B=0x3F800000, spl_case=0, out_ready=1 → result 0x40000000 at accept+3; ovf=0, invalid=0.
- A=0x3FC00000, B=0x40100000 → 0x40700000. A=0x3F800000, B=0xBF800000 → 0x00000000.
- Rounding:
  - A=0x3F800000, B=0x33800000 (tie) → 0x3F800000.
  - B=0x33C00000 (above half) → 0x3F800001.
- Overflow and invalid:
  - A=B=0x7F7FFFFF → 0x7F800000, ovf=1.
  - A=0x7F800000, B=0xFF800000, spl_case=0 → 0x7FC00000, invalid=1.
- Bypass: spl_case=1, spl_result=0x7FC00000, any A/B → 0x7FC00000, invalid=1, emitted in order between two normal adds issued back-to-back.
- Back-pressure:
  - Stimulus: issue 4 ops, drop out_ready for 5 cycles after the first output, assert rst once mid-stream in a separate run.
  - Stall: in_ready=0 and result held stable during the stall; after release, all 4 results arrive in order with no loss or duplication.
  - Reset run: out_valid=0 immediately, no stale outputs afterwards.
